// File: rtl/ofs_plat_axi_mem_lite_if_arb_if.sv
// AXI-lite memory interface shared by the arbiter's sink and source ports.
// to_sink is the view of the side that issues requests toward a memory sink;
// to_source is the view of the side that answers requests coming from a source.
interface ofs_plat_axi_mem_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;

  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;

  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;

  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;

  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport to_sink (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport to_source (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ofs_plat_axi_mem_lite_if_arb.sv
// Round-robin arbiter sharing one AXI-lite memory sink among NUM_SOURCES
// sources. Payloads and valids are forwarded combinationally; only the
// arbitration pointers, the write-pair lock and the ordering FIFOs are state.

// Ordering FIFO: records which source owns each outstanding request.
module ofs_plat_axi_mem_lite_if_arb_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Full is evaluated on the current count, so a same-cycle pop never frees a push.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_idx];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage, pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the entries are reset too because every flop must clear on reset;
      // a pure data RAM would normally be left unreset so it maps to memory.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // independent of statement order.
      if (do_push) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= wr_idx + 1'b1;
      end
      if (do_pop) rd_idx <= rd_idx + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module ofs_plat_axi_mem_lite_if_arb #(
  parameter int NUM_SOURCES     = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                              clk,
  input  logic                              reset_n,
  ofs_plat_axi_mem_lite_if.to_sink          mem_sink,
  ofs_plat_axi_mem_lite_if.to_source        mem_source [NUM_SOURCES]
);
  localparam int IDX_W  = $clog2(NUM_SOURCES);
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {WR_IDLE, WR_AW_DONE, WR_W_DONE} wr_state_t;

  // First requester at or after ptr, wrapping modulo NUM_SOURCES.
  function automatic idx_t rr_pick(input logic [NUM_SOURCES-1:0] req, input idx_t ptr);
    idx_t pick;
    int   j;
    pick = ptr;
    for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_SOURCES) j -= NUM_SOURCES;
      if (req[j]) pick = idx_t'(j);
    end
    return pick;
  endfunction

  function automatic idx_t next_idx(input idx_t i);
    return (int'(i) == NUM_SOURCES - 1) ? '0 : idx_t'(i + 1'b1);
  endfunction

  // Flattened per-source views, since interface arrays only take constant indices.
  logic [NUM_SOURCES-1:0] src_awvalid, src_wvalid, src_arvalid, src_bready, src_rready;
  logic [NUM_SOURCES-1:0] src_awready, src_wready, src_arready, src_bvalid, src_rvalid;
  logic [ADDR_WIDTH-1:0]  src_awaddr [NUM_SOURCES];
  logic [ADDR_WIDTH-1:0]  src_araddr [NUM_SOURCES];
  logic [2:0]             src_awprot [NUM_SOURCES];
  logic [2:0]             src_arprot [NUM_SOURCES];
  logic [DATA_WIDTH-1:0]  src_wdata  [NUM_SOURCES];
  logic [STRB_W-1:0]      src_wstrb  [NUM_SOURCES];

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    assign src_awvalid[i] = mem_source[i].awvalid;
    assign src_awaddr[i]  = mem_source[i].awaddr;
    assign src_awprot[i]  = mem_source[i].awprot;
    assign src_wvalid[i]  = mem_source[i].wvalid;
    assign src_wdata[i]   = mem_source[i].wdata;
    assign src_wstrb[i]   = mem_source[i].wstrb;
    assign src_arvalid[i] = mem_source[i].arvalid;
    assign src_araddr[i]  = mem_source[i].araddr;
    assign src_arprot[i]  = mem_source[i].arprot;
    assign src_bready[i]  = mem_source[i].bready;
    assign src_rready[i]  = mem_source[i].rready;

    assign mem_source[i].awready = src_awready[i];
    assign mem_source[i].wready  = src_wready[i];
    assign mem_source[i].arready = src_arready[i];
    assign mem_source[i].bvalid  = src_bvalid[i];
    assign mem_source[i].bresp   = mem_sink.bresp;
    assign mem_source[i].rvalid  = src_rvalid[i];
    assign mem_source[i].rdata   = mem_sink.rdata;
    assign mem_source[i].rresp   = mem_sink.rresp;

    // Simulation-only check that every source's payloads match the sink's widths.
    always_ff @(posedge clk) begin
      if (reset_n) begin
        assert ($bits(mem_source[i].awaddr) == $bits(mem_sink.awaddr) &&
                $bits(mem_source[i].wdata)  == $bits(mem_sink.wdata)  &&
                $bits(mem_source[i].rdata)  == $bits(mem_sink.rdata))
          else $error("source %0d payload widths differ from the sink", i);
      end
    end
  end

  // Arbitration state.
  wr_state_t wr_state, wr_state_nxt;
  idx_t      wr_ptr, wr_ptr_nxt;
  idx_t      lock_src, lock_src_nxt;
  idx_t      rd_ptr;

  // Datapath control.
  logic [NUM_SOURCES-1:0] wr_req;
  idx_t wr_gnt, rd_gnt, b_head, r_head;
  logic wr_active, aw_open, w_open, rd_open;
  logic sink_awvalid, sink_wvalid, sink_arvalid, sink_bready, sink_rready;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic wfifo_full, wfifo_empty, rfifo_full, rfifo_empty;

  assign wr_req = src_awvalid | src_wvalid;
  assign wr_gnt = (wr_state == WR_IDLE) ? rr_pick(wr_req, wr_ptr) : lock_src;
  assign rd_gnt = rr_pick(src_arvalid, rd_ptr);

  // Grant routing, lock masking and response steering; outputs stay quiet in reset.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    src_awready = '0;
    src_wready  = '0;
    src_arready = '0;
    src_bvalid  = '0;
    src_rvalid  = '0;

    wr_active = reset_n & ((wr_state != WR_IDLE) | (|wr_req));
    aw_open   = wr_active & (wr_state != WR_AW_DONE) & ~wfifo_full;
    w_open    = wr_active & (wr_state != WR_W_DONE);
    rd_open   = reset_n & ~rfifo_full;

    sink_awvalid = aw_open & src_awvalid[wr_gnt];
    sink_wvalid  = w_open & src_wvalid[wr_gnt];
    sink_arvalid = rd_open & src_arvalid[rd_gnt];
    src_awready[wr_gnt] = aw_open & mem_sink.awready;
    src_wready[wr_gnt]  = w_open & mem_sink.wready;
    src_arready[rd_gnt] = rd_open & mem_sink.arready;

    sink_bready = reset_n & ~wfifo_empty & src_bready[b_head];
    sink_rready = reset_n & ~rfifo_empty & src_rready[r_head];
    src_bvalid[b_head] = reset_n & ~wfifo_empty & mem_sink.bvalid;
    src_rvalid[r_head] = reset_n & ~rfifo_empty & mem_sink.rvalid;
  end

  assign aw_hs = sink_awvalid & mem_sink.awready;
  assign w_hs  = sink_wvalid & mem_sink.wready;
  assign ar_hs = sink_arvalid & mem_sink.arready;
  assign b_hs  = mem_sink.bvalid & sink_bready;
  assign r_hs  = mem_sink.rvalid & sink_rready;

  assign mem_sink.awvalid = sink_awvalid;
  assign mem_sink.awaddr  = src_awaddr[wr_gnt];
  assign mem_sink.awprot  = src_awprot[wr_gnt];
  assign mem_sink.wvalid  = sink_wvalid;
  assign mem_sink.wdata   = src_wdata[wr_gnt];
  assign mem_sink.wstrb   = src_wstrb[wr_gnt];
  assign mem_sink.arvalid = sink_arvalid;
  assign mem_sink.araddr  = src_araddr[rd_gnt];
  assign mem_sink.arprot  = src_arprot[rd_gnt];
  assign mem_sink.bready  = sink_bready;
  assign mem_sink.rready  = sink_rready;

  // Write lock: a half-completed AW/W pair pins the grant until the other half lands.
  always_comb begin
    wr_state_nxt = wr_state;
    wr_ptr_nxt   = wr_ptr;
    lock_src_nxt = lock_src;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_ptr_nxt = next_idx(wr_gnt);
        end else if (aw_hs) begin
          wr_state_nxt = WR_AW_DONE;
          lock_src_nxt = wr_gnt;
        end else if (w_hs) begin
          wr_state_nxt = WR_W_DONE;
          lock_src_nxt = wr_gnt;
        end
      end
      WR_AW_DONE: begin
        if (w_hs) begin
          wr_state_nxt = WR_IDLE;
          wr_ptr_nxt   = next_idx(lock_src);
        end
      end
      WR_W_DONE: begin
        if (aw_hs) begin
          wr_state_nxt = WR_IDLE;
          wr_ptr_nxt   = next_idx(lock_src);
        end
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  // Write arbitration state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state <= WR_IDLE;
      wr_ptr   <= '0;
      lock_src <= '0;
    end else begin
      wr_state <= wr_state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      lock_src <= lock_src_nxt;
    end
  end

  // Read pointer advances past the winner on every sink AR handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_ptr <= '0;
    else if (ar_hs) rd_ptr <= next_idx(rd_gnt);
  end

  ofs_plat_axi_mem_lite_if_arb_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(IDX_W)) wr_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (aw_hs),
    .push_data (wr_gnt),
    .pop       (b_hs),
    .head      (b_head),
    .full      (wfifo_full),
    .empty     (wfifo_empty)
  );

  ofs_plat_axi_mem_lite_if_arb_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(IDX_W)) rd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (ar_hs),
    .push_data (rd_gnt),
    .pop       (r_hs),
    .head      (r_head),
    .full      (rfifo_full),
    .empty     (rfifo_empty)
  );

  // Simulation-only protocol checks: a response with nothing outstanding is a sink bug.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(mem_sink.bvalid && wfifo_empty)) else $error("sink B response with no outstanding write");
      assert (!(mem_sink.rvalid && rfifo_empty)) else $error("sink R response with no outstanding read");
    end
  end
endmodule

// File: tb/tb_ofs_plat_axi_mem_lite_if_arb.sv
// Directed bench for the AXI-lite arbiter: four sources, eight-deep ordering FIFOs.
module tb_ofs_plat_axi_mem_lite_if_arb;
  localparam int N = 4;
  localparam int D = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Source-side stimulus and observations.
  logic [N-1:0] s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready;
  logic [N-1:0] s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [31:0]  s_awaddr [N];
  logic [31:0]  s_araddr [N];
  logic [31:0]  s_wdata  [N];
  logic [31:0]  s_rdata  [N];

  // Sink-side stimulus and observations.
  logic        k_awready, k_wready, k_arready, k_bvalid, k_rvalid;
  logic [31:0] k_rdata;
  logic        k_awvalid, k_wvalid, k_arvalid, k_bready, k_rready;
  logic [31:0] k_awaddr, k_araddr, k_wdata;

  ofs_plat_axi_mem_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) sink_if ();
  ofs_plat_axi_mem_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) src_if [N] ();

  for (genvar g = 0; g < N; g++) begin : g_wire
    assign src_if[g].awvalid = s_awvalid[g];
    assign src_if[g].awaddr  = s_awaddr[g];
    assign src_if[g].awprot  = 3'b000;
    assign src_if[g].wvalid  = s_wvalid[g];
    assign src_if[g].wdata   = s_wdata[g];
    assign src_if[g].wstrb   = 4'hF;
    assign src_if[g].arvalid = s_arvalid[g];
    assign src_if[g].araddr  = s_araddr[g];
    assign src_if[g].arprot  = 3'b000;
    assign src_if[g].bready  = s_bready[g];
    assign src_if[g].rready  = s_rready[g];
    assign s_awready[g] = src_if[g].awready;
    assign s_wready[g]  = src_if[g].wready;
    assign s_arready[g] = src_if[g].arready;
    assign s_bvalid[g]  = src_if[g].bvalid;
    assign s_rvalid[g]  = src_if[g].rvalid;
    assign s_rdata[g]   = src_if[g].rdata;
  end

  assign sink_if.awready = k_awready;
  assign sink_if.wready  = k_wready;
  assign sink_if.arready = k_arready;
  assign sink_if.bvalid  = k_bvalid;
  assign sink_if.bresp   = 2'b00;
  assign sink_if.rvalid  = k_rvalid;
  assign sink_if.rdata   = k_rdata;
  assign sink_if.rresp   = 2'b00;
  assign k_awvalid = sink_if.awvalid;
  assign k_awaddr  = sink_if.awaddr;
  assign k_wvalid  = sink_if.wvalid;
  assign k_wdata   = sink_if.wdata;
  assign k_arvalid = sink_if.arvalid;
  assign k_araddr  = sink_if.araddr;
  assign k_bready  = sink_if.bready;
  assign k_rready  = sink_if.rready;

  ofs_plat_axi_mem_lite_if_arb #(
    .NUM_SOURCES(N), .MAX_OUTSTANDING(D), .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_sink   (sink_if),
    .mem_source (src_if)
  );

  // Source i writes to 0x100*(i+1) with data 0xD0+i; reads use 0x200+i.
  task automatic idle_inputs();
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
    s_bready = '1;  s_rready = '1;
    for (int i = 0; i < N; i++) begin
      s_awaddr[i] = 32'h100 * (i + 1);
      s_wdata[i]  = 32'hD0 + i;
      s_araddr[i] = 32'h200 + i;
    end
    k_awready = 1'b1; k_wready = 1'b1; k_arready = 1'b1;
    k_bvalid = 1'b0; k_rvalid = 1'b0; k_rdata = '0;
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Sample point, well clear of both clock edges.
  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    s_awvalid = '1; s_wvalid = '1; s_arvalid = '1;
    repeat (2) @(posedge clk);
    settle();
    total_cnt++; if ({k_awvalid, k_wvalid, k_arvalid, k_bready, k_rready} !== 5'b0) $display("FAIL reset_sink_ctrl: got %b want 00000", {k_awvalid, k_wvalid, k_arvalid, k_bready, k_rready}); else pass_cnt++;
    total_cnt++; if ({s_awready, s_wready, s_arready} !== 12'b0) $display("FAIL reset_src_ready: got %b want 0", {s_awready, s_wready, s_arready}); else pass_cnt++;
    total_cnt++; if ({s_bvalid, s_rvalid} !== 8'b0) $display("FAIL reset_src_resp: got %b want 0", {s_bvalid, s_rvalid}); else pass_cnt++;
    cycle();
    reset_n = 1'b1;
    settle();
    total_cnt++; if (s_awready !== 4'b0001) $display("FAIL reset_first_aw_grant: got %b want 0001", s_awready); else pass_cnt++;
    total_cnt++; if (s_arready !== 4'b0001) $display("FAIL reset_first_ar_grant: got %b want 0001", s_arready); else pass_cnt++;
    total_cnt++; if (k_awaddr !== 32'h100) $display("FAIL reset_first_awaddr: got %h want 00000100", k_awaddr); else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_split_lock();
    do_reset();
    // Source 0 completes one write first so the write pointer moves to 1.
    s_awvalid = 4'b0001; s_wvalid = 4'b0001;
    cycle();
    s_awvalid = '0; s_wvalid = '0; k_bvalid = 1'b1;
    settle();
    total_cnt++; if (s_bvalid !== 4'b0001) $display("FAIL lock_prime_b: got %b want 0001", s_bvalid); else pass_cnt++;
    cycle();
    k_bvalid = 1'b0;
    // Cycle 0: AW from source 1 lands, W stalls at the sink.
    s_awvalid = 4'b0011; s_wvalid = 4'b0011; k_wready = 1'b0;
    settle();
    total_cnt++; if (s_awready !== 4'b0010) $display("FAIL lock_c0_awready: got %b want 0010", s_awready); else pass_cnt++;
    total_cnt++; if (k_awaddr !== 32'h200) $display("FAIL lock_c0_awaddr: got %h want 00000200", k_awaddr); else pass_cnt++;
    cycle();
    s_awvalid = 4'b0001;
    // Cycles 1-2: only source 1's W is routed; AW is masked.
    for (int c = 1; c <= 2; c++) begin
      settle();
      total_cnt++; if (k_awvalid !== 1'b0) $display("FAIL lock_c%0d_awvalid: got %b want 0", c, k_awvalid); else pass_cnt++;
      total_cnt++; if (k_wvalid !== 1'b1 || k_wdata !== 32'hD1) $display("FAIL lock_c%0d_w: got v=%b d=%h want v=1 d=000000d1", c, k_wvalid, k_wdata); else pass_cnt++;
      total_cnt++; if (s_awready !== 4'b0000) $display("FAIL lock_c%0d_awready: got %b want 0000", c, s_awready); else pass_cnt++;
      cycle();
    end
    // Cycle 3: source 1's W completes; source 0 still blocked.
    k_wready = 1'b1;
    settle();
    total_cnt++; if (s_wready !== 4'b0010 || s_awready !== 4'b0000) $display("FAIL lock_c3_ready: got w=%b aw=%b want w=0010 aw=0000", s_wready, s_awready); else pass_cnt++;
    cycle();
    s_wvalid = 4'b0001;
    // Cycle 4: source 0 granted.
    settle();
    total_cnt++; if (s_awready !== 4'b0001 || s_wready !== 4'b0001) $display("FAIL lock_c4_grant: got aw=%b w=%b want 0001/0001", s_awready, s_wready); else pass_cnt++;
    total_cnt++; if (k_awaddr !== 32'h100) $display("FAIL lock_c4_awaddr: got %h want 00000100", k_awaddr); else pass_cnt++;
    cycle();
    s_awvalid = '0; s_wvalid = '0;
    // Responses return in issue order: source 1 then source 0.
    k_bvalid = 1'b1;
    settle();
    total_cnt++; if (s_bvalid !== 4'b0010) $display("FAIL lock_b1_route: got %b want 0010", s_bvalid); else pass_cnt++;
    cycle();
    settle();
    total_cnt++; if (s_bvalid !== 4'b0001) $display("FAIL lock_b0_route: got %b want 0001", s_bvalid); else pass_cnt++;
    cycle();
    k_bvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    s_awvalid = 4'b0011; s_wvalid = 4'b0011;
    settle();
    total_cnt++; if (s_awready !== 4'b0001 || s_wready !== 4'b0001) $display("FAIL b2b_first: got aw=%b w=%b want 0001/0001", s_awready, s_wready); else pass_cnt++;
    cycle();
    s_awvalid = 4'b0010; s_wvalid = 4'b0010;
    settle();
    total_cnt++; if (s_awready !== 4'b0010 || s_wready !== 4'b0010) $display("FAIL b2b_second: got aw=%b w=%b want 0010/0010", s_awready, s_wready); else pass_cnt++;
    total_cnt++; if (k_awaddr !== 32'h200) $display("FAIL b2b_awaddr: got %h want 00000200", k_awaddr); else pass_cnt++;
    cycle();
    s_awvalid = '0; s_wvalid = '0;
    k_bvalid = 1'b1;
    settle();
    total_cnt++; if (s_bvalid !== 4'b0001) $display("FAIL b2b_b0: got %b want 0001", s_bvalid); else pass_cnt++;
    cycle();
    settle();
    total_cnt++; if (s_bvalid !== 4'b0010) $display("FAIL b2b_b1: got %b want 0010", s_bvalid); else pass_cnt++;
    cycle();
    k_bvalid = 1'b0;
  endtask

  task automatic test_rr_fairness();
    int ar_left [N];
    int rx_cnt [N];
    logic [31:0] sink_q [$];
    int issued;
    int cyc_n;
    int src;
    do_reset();
    for (int i = 0; i < N; i++) begin ar_left[i] = 8; rx_cnt[i] = 0; end
    issued = 0;
    cyc_n = 0;
    while ((issued < 32 || sink_q.size() > 0) && cyc_n < 200) begin
      for (int i = 0; i < N; i++) begin
        s_arvalid[i] = (ar_left[i] > 0);
        s_araddr[i]  = 32'(i * 256 + (8 - ar_left[i]));
      end
      k_rvalid = (sink_q.size() > 0);
      k_rdata  = k_rvalid ? sink_q[0] : 32'h0;
      settle();
      if (k_rvalid) begin
        src = int'(k_rdata[15:8]);
        total_cnt++; if (s_rvalid !== 4'(1 << src) || k_rready !== 1'b1) $display("FAIL rr_r_route: got rvalid=%b rready=%b want %b/1", s_rvalid, k_rready, 4'(1 << src)); else pass_cnt++;
        total_cnt++; if (int'(k_rdata[7:0]) !== rx_cnt[src]) $display("FAIL rr_r_order src%0d: got beat %0d want %0d", src, k_rdata[7:0], rx_cnt[src]); else pass_cnt++;
        rx_cnt[src]++;
        void'(sink_q.pop_front());
      end
      if (k_arvalid && k_arready) begin
        src = int'(k_araddr[15:8]);
        total_cnt++; if (src !== issued % N || s_arready !== 4'(1 << (issued % N))) $display("FAIL rr_grant %0d: got src %0d arready=%b want src %0d", issued, src, s_arready, issued % N); else pass_cnt++;
        sink_q.push_back(k_araddr);
        if (src < N) ar_left[src]--;
        issued++;
      end
      cycle();
      cyc_n++;
    end
    s_arvalid = '0; k_rvalid = 1'b0;
    total_cnt++; if (cyc_n >= 200) $display("FAIL rr_timeout: got %0d cycles want under 200", cyc_n); else pass_cnt++;
    for (int i = 0; i < N; i++) begin
      total_cnt++; if (rx_cnt[i] !== 8) $display("FAIL rr_beats src%0d: got %0d want 8", i, rx_cnt[i]); else pass_cnt++;
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    s_awvalid = 4'b0001; s_wvalid = 4'b0001;
    for (int c = 0; c < D; c++) begin
      settle();
      total_cnt++; if (k_awvalid !== 1'b1) $display("FAIL full_fill%0d: got awvalid %b want 1", c, k_awvalid); else pass_cnt++;
      cycle();
    end
    // Ninth write: AW blocked by the full FIFO, W still forwarded.
    settle();
    total_cnt++; if (k_awvalid !== 1'b0 || s_awready !== 4'b0000) $display("FAIL full_ninth_aw: got awvalid=%b awready=%b want 0/0000", k_awvalid, s_awready); else pass_cnt++;
    total_cnt++; if (k_wvalid !== 1'b1 || s_wready !== 4'b0001) $display("FAIL full_ninth_w: got wvalid=%b wready=%b want 1/0001", k_wvalid, s_wready); else pass_cnt++;
    cycle();
    s_wvalid = '0;
    // A pop in this cycle does not open a slot until the next.
    k_bvalid = 1'b1;
    settle();
    total_cnt++; if (s_bvalid !== 4'b0001 || k_awvalid !== 1'b0) $display("FAIL full_pop_cycle: got bvalid=%b awvalid=%b want 0001/0", s_bvalid, k_awvalid); else pass_cnt++;
    cycle();
    k_bvalid = 1'b0;
    settle();
    total_cnt++; if (k_awvalid !== 1'b1 || s_awready !== 4'b0001) $display("FAIL full_ninth_issue: got awvalid=%b awready=%b want 1/0001", k_awvalid, s_awready); else pass_cnt++;
    cycle();
    s_awvalid = '0;
    k_bvalid = 1'b1;
    for (int c = 0; c < D; c++) begin
      settle();
      total_cnt++; if (s_bvalid !== 4'b0001) $display("FAIL full_drain%0d: got %b want 0001", c, s_bvalid); else pass_cnt++;
      cycle();
    end
    k_bvalid = 1'b0;
    settle();
    total_cnt++; if (k_bready !== 1'b0) $display("FAIL full_empty_bready: got %b want 0", k_bready); else pass_cnt++;
    cycle();
  endtask

  task automatic test_resp_routing();
    logic [N-1:0] ar_seq [3];
    logic [31:0]  rd_seq [3];
    ar_seq[0] = 4'b0100; ar_seq[1] = 4'b0001; ar_seq[2] = 4'b0100;
    rd_seq[0] = 32'hA;   rd_seq[1] = 32'hB;   rd_seq[2] = 32'hC;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      s_arvalid = ar_seq[c];
      settle();
      total_cnt++; if (s_arready !== ar_seq[c]) $display("FAIL route_ar%0d: got %b want %b", c, s_arready, ar_seq[c]); else pass_cnt++;
      cycle();
    end
    s_arvalid = '0;
    // Source 2 back-pressures the first response for one cycle.
    s_rready = 4'b1011; k_rvalid = 1'b1; k_rdata = rd_seq[0];
    settle();
    total_cnt++; if (k_rready !== 1'b0 || s_rvalid !== 4'b0100) $display("FAIL route_backpressure: got rready=%b rvalid=%b want 0/0100", k_rready, s_rvalid); else pass_cnt++;
    cycle();
    s_rready = '1;
    for (int c = 0; c < 3; c++) begin
      k_rdata = rd_seq[c];
      settle();
      total_cnt++; if (s_rvalid !== ar_seq[c] || k_rready !== 1'b1) $display("FAIL route_r%0d: got rvalid=%b rready=%b want %b/1", c, s_rvalid, k_rready, ar_seq[c]); else pass_cnt++;
      total_cnt++; if (s_rdata[(c == 1) ? 0 : 2] !== rd_seq[c]) $display("FAIL route_rdata%0d: got %h want %h", c, s_rdata[(c == 1) ? 0 : 2], rd_seq[c]); else pass_cnt++;
      cycle();
    end
    k_rvalid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_split_lock();
    test_back_to_back();
    test_rr_fairness();
    test_fifo_full();
    test_resp_routing();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
